mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 21 ++
 rtl/mem_port_arbiter_timeout_ctr.sv | 39 +++
 rtl/mem_port_arbiter.sv | 171 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared CPU memory-port types: arbiter FSM encoding, parameter defaults and
// the sizing helper for the fetch starvation counter.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      IBUSY = 2'd1,
      DBUSY = 2'd2,
      RESP  = 2'd3
   } arb_state_e;

   localparam int unsigned TIMEOUT_DEF    = 16;
   localparam int unsigned STARVE_MAX_DEF = 3;
   localparam int unsigned WAIT_W         = 8;

   // Starvation counter must hold STARVE_MAX and is never narrower than 2 bits.
   function automatic int unsigned starve_width(input int unsigned max_val);
      return ($clog2(max_val + 1) < 2) ? 2 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/mem_port_arbiter_timeout_ctr.sv
// Wait-cycle counter for an outstanding memory access: clear/load/increment,
// term_o flags the LIMIT-th counted cycle so the owner can abort on that edge.
module arb_timeout_ctr #(
   parameter int unsigned W     = 8,
   parameter int unsigned LIMIT = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr_i,
   input  logic         ld_i,
   input  logic [W-1:0] ld_val_i,
   input  logic         inc_i,
   output logic         term_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (ld_i) begin
         cnt_d = ld_val_i;
      end else if (inc_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign term_o = inc_i && (cnt_q == W'(LIMIT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data requests onto one single-port memory: data wins unless
// fetch has lost STARVE_MAX grants in a row; each access ends in a one-cycle RESP.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned TIMEOUT    = TIMEOUT_DEF,
   parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   input  logic        d_req,
   input  logic        d_flush,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        i_ack,
   output logic        d_ack,
   output logic [31:0] i_rdata,
   output logic [31:0] d_rdata,
   output logic        stall_f,
   output logic        stall_m,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        bus_err
);

   localparam int unsigned   SW         = starve_width(STARVE_MAX);
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

   arb_state_e    state_q, state_d;
   logic [SW-1:0] starve_q, starve_d;
   logic          mem_req_q, mem_req_d;
   logic          mem_we_q, mem_we_d;
   logic [31:0]   mem_addr_q, mem_addr_d;
   logic [31:0]   mem_wdata_q, mem_wdata_d;
   logic          i_ack_q, i_ack_d;
   logic          d_ack_q, d_ack_d;
   logic          bus_err_q, bus_err_d;
   logic [31:0]   i_rdata_q, i_rdata_d;
   logic [31:0]   d_rdata_q, d_rdata_d;
   logic          wait_clr, wait_inc, wait_term;
   logic          d_grant, i_grant;

   // A flushed data request is invisible to arbitration, so fetch may take the slot.
   assign d_grant = (state_q == IDLE) && d_req && !d_flush && (!i_req || (starve_q < STARVE_LIM));
   assign i_grant = (state_q == IDLE) && i_req && !d_grant;

   arb_timeout_ctr #(
      .W     (WAIT_W),
      .LIMIT (TIMEOUT)
   ) u_wait_ctr (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_i    (wait_clr),
      .ld_i     (1'b0),
      .ld_val_i ('0),
      .inc_i    (wait_inc),
      .term_o   (wait_term)
   );

   always_comb begin
      state_d     = state_q;
      starve_d    = starve_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      i_ack_d     = 1'b0;
      d_ack_d     = 1'b0;
      bus_err_d   = 1'b0;
      i_rdata_d   = i_rdata_q;
      d_rdata_d   = d_rdata_q;
      wait_clr    = 1'b0;
      wait_inc    = 1'b0;

      if (!i_req || i_grant) begin
         starve_d = '0;
      end else if (d_grant && (starve_q < STARVE_LIM)) begin
         starve_d = starve_q + 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (d_grant) begin
               state_d     = DBUSY;
               mem_req_d   = 1'b1;
               mem_we_d    = d_we;
               mem_addr_d  = d_addr;
               mem_wdata_d = d_wdata;
               wait_clr    = 1'b1;
            end else if (i_grant) begin
               state_d    = IBUSY;
               mem_req_d  = 1'b1;
               mem_we_d   = 1'b0;
               mem_addr_d = i_addr;
               wait_clr   = 1'b1;
            end
         end
         IBUSY, DBUSY: begin
            wait_inc = 1'b1;
            // A late mem_ack on the terminal cycle still counts as a normal completion.
            if (mem_ack || wait_term) begin
               state_d   = RESP;
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               bus_err_d = ~mem_ack;
               if (state_q == IBUSY) begin
                  i_ack_d = 1'b1;
                  if (mem_ack) i_rdata_d = mem_rdata;
               end else begin
                  d_ack_d = 1'b1;
                  if (mem_ack && !mem_we_q) d_rdata_d = mem_rdata;
               end
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         starve_q    <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 32'h0000_0000;
         mem_wdata_q <= 32'h0000_0000;
         i_ack_q     <= 1'b0;
         d_ack_q     <= 1'b0;
         bus_err_q   <= 1'b0;
         i_rdata_q   <= 32'h0000_0000;
         d_rdata_q   <= 32'h0000_0000;
      end else begin
         state_q     <= state_d;
         starve_q    <= starve_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         i_ack_q     <= i_ack_d;
         d_ack_q     <= d_ack_d;
         bus_err_q   <= bus_err_d;
         i_rdata_q   <= i_rdata_d;
         d_rdata_q   <= d_rdata_d;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign i_ack     = i_ack_q;
   assign d_ack     = d_ack_q;
   assign bus_err   = bus_err_q;
   assign i_rdata   = i_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign stall_f   = i_req & ~i_ack_q;
   assign stall_m   = d_req & ~d_flush & ~d_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios then randomized traffic, checked
// against a transaction-timeline model (grant cycle + memory latency arithmetic).
module tb_mem_port_arbiter;

   localparam int TO = 16;
   localparam int SM = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_req = 1'b0, d_req = 1'b0, d_flush = 1'b0, d_we = 1'b0;
   logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
   logic        i_ack, d_ack, stall_f, stall_m, mem_req, mem_we, bus_err;
   logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;

   mem_port_arbiter #(.TIMEOUT(TO), .STARVE_MAX(SM)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req), .i_addr(i_addr),
      .d_req(d_req), .d_flush(d_flush), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .i_ack(i_ack), .d_ack(d_ack), .i_rdata(i_rdata), .d_rdata(d_rdata),
      .stall_f(stall_f), .stall_m(stall_m),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   int vectors = 0, miscompares = 0;
   int t = 0;

   // Reference model: one outstanding access described by grant cycle and latency.
   bit          act = 0, a_we = 0;
   int          a_who = 0, a_g = 0, a_lat = 0, a_end = 0, a_ack = 0;
   logic [31:0] a_addr = '0, a_wdata = '0, a_rdata = '0;
   int          idle_from = 0, starve = 0, next_lat = 0;
   logic [31:0] i_rdata_m = '0, d_rdata_m = '0;
   bit          i_acked = 0, d_acked = 0, d_cancel = 0;
   bit          fix_rd = 0;
   logic [31:0] fix_val = '0;

   // Observations of the DUT used by directed scenarios.
   bit          obs_iack = 0, obs_dack = 0, obs_berr = 0, prev_mreq = 0;
   int          mreq_hi = 0, n_iack = 0, n_dack = 0;
   logic [31:0] dut_grants[$];

   task automatic chk1(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, t);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, t);
      end
   endtask

   // One clock cycle: drive memory, check outputs, advance the model, move to next negedge.
   task automatic cycle();
      bit busy, ack_now, to, gi, gd;
      busy    = act && (t > a_g) && (t <= a_end);
      ack_now = act && (t == a_ack);
      to      = act && (a_lat > TO);
      mem_rdata = fix_rd ? fix_val : $urandom;
      mem_ack   = 1'b0;
      if (busy && (t == a_g + a_lat)) begin
         mem_ack = 1'b1;
         a_rdata = mem_rdata;
      end else if (!busy && ($urandom_range(0, 3) == 0)) begin
         mem_ack = 1'b1;
      end
      #1;
      if (ack_now && !to) begin
         if (a_who == 1) i_rdata_m = a_rdata;
         else if (!a_we) d_rdata_m = a_rdata;
      end
      i_acked = ack_now && (a_who == 1);
      d_acked = ack_now && (a_who == 2);
      chk1("mem_req", mem_req, busy);
      if (busy) begin
         chk32("mem_addr", mem_addr, a_addr);
         chk1("mem_we", mem_we, a_we);
         if (a_we) chk32("mem_wdata", mem_wdata, a_wdata);
      end
      chk1("i_ack", i_ack, i_acked);
      chk1("d_ack", d_ack, d_acked);
      chk1("bus_err", bus_err, ack_now && to);
      chk32("i_rdata", i_rdata, i_rdata_m);
      chk32("d_rdata", d_rdata, d_rdata_m);
      chk1("stall_f", stall_f, i_req && !i_acked);
      chk1("stall_m", stall_m, d_req && !d_flush && !d_acked);
      obs_iack = (i_ack === 1'b1);
      obs_dack = (d_ack === 1'b1);
      obs_berr = (bus_err === 1'b1);
      if (mem_req === 1'b1) mreq_hi++;
      if (i_ack === 1'b1) n_iack++;
      if (d_ack === 1'b1) n_dack++;
      if ((mem_req === 1'b1) && !prev_mreq) dut_grants.push_back(mem_addr);
      prev_mreq = (mem_req === 1'b1);
      gi = 0;
      gd = 0;
      if (t >= idle_from) begin
         if (d_req && !d_flush && (!i_req || starve < SM)) gd = 1;
         else if (i_req) gi = 1;
      end
      if (!i_req || gi) starve = 0;
      else if (gd && starve < SM) starve++;
      if (gi || gd) begin
         act     = 1;
         a_who   = gi ? 1 : 2;
         a_g     = t;
         a_lat   = (next_lat != 0) ? next_lat :
                   (($urandom_range(0, 15) == 0) ? 20 : int'($urandom_range(1, 5)));
         a_addr  = gi ? i_addr : d_addr;
         a_we    = gd && d_we;
         a_wdata = d_wdata;
         a_end   = a_g + ((a_lat > TO) ? TO : a_lat);
         a_ack   = a_end + 1;
         idle_from = a_ack + 1;
      end
      @(negedge clk);
      t++;
   endtask

   task automatic run_until_ack(input bit want_i, input int budget, input string tag);
      int  n;
      bit  seen;
      n    = 0;
      seen = 0;
      while (!seen && n < budget) begin
         cycle();
         seen = want_i ? obs_iack : obs_dack;
         n++;
      end
      vectors++;
      assert (seen === 1'b1) else begin
         miscompares++;
         $error("FAIL %s: ack observed %0b expected 1 within %0d cycles", tag, seen, budget);
      end
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      d_flush = 1'b0;
      while ((i_req || d_req) && n < budget) begin
         cycle();
         if (i_acked) i_req = 1'b0;
         if (d_acked) d_req = 1'b0;
         n++;
      end
      vectors++;
      assert (!(i_req || d_req)) else begin
         miscompares++;
         $error("FAIL drain: requests pending observed 1 expected 0 after %0d cycles", budget);
      end
   endtask

   task automatic idle(input int n);
      i_req   = 1'b0;
      d_req   = 1'b0;
      d_flush = 1'b0;
      repeat (n) cycle();
   endtask

   logic [31:0] exp033 [5];

   initial begin
      exp033 = '{32'h2222_0000, 32'h2222_0000, 32'h2222_0000, 32'h1111_0000, 32'h2222_0000};

      // Reset values
      repeat (3) @(negedge clk);
      #1;
      chk1("rst_mem_req", mem_req, 1'b0);
      chk1("rst_mem_we", mem_we, 1'b0);
      chk1("rst_i_ack", i_ack, 1'b0);
      chk1("rst_d_ack", d_ack, 1'b0);
      chk1("rst_bus_err", bus_err, 1'b0);
      chk32("rst_mem_addr", mem_addr, 32'h0);
      chk32("rst_mem_wdata", mem_wdata, 32'h0);
      chk32("rst_i_rdata", i_rdata, 32'h0);
      chk32("rst_d_rdata", d_rdata, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);

      // Single fetch, memory answers on the third busy cycle with a fixed word
      fix_rd = 1;
      fix_val = 32'hDEAD_BEEF;
      next_lat = 3;
      n_iack = 0;
      i_req = 1'b1;
      i_addr = 32'h0000_0100;
      run_until_ack(1, 30, "i_ack_single");
      chk32("i_rdata_single", i_rdata, 32'hDEAD_BEEF);
      i_req = 1'b0;
      idle(3);
      chk1("stall_f_after_ack", stall_f, 1'b0);
      chk32("i_ack_pulses", 32'(n_iack), 32'd1);
      fix_rd = 0;

      // Simultaneous requests: data first, fetch after RESP
      next_lat = 2;
      dut_grants.delete();
      i_req = 1'b1;
      i_addr = 32'h0000_0400;
      d_req = 1'b1;
      d_we = 1'b0;
      d_addr = 32'h0000_2000;
      cycle();
      #1;
      chk32("first_grant_addr", mem_addr, 32'h0000_2000);
      run_until_ack(0, 20, "d_ack_simul");
      d_req = 1'b0;
      run_until_ack(1, 20, "i_ack_simul");
      i_req = 1'b0;
      idle(2);
      chk32("grant0_simul", (dut_grants.size() > 0) ? dut_grants[0] : 32'hx, 32'h0000_2000);
      chk32("grant1_simul", (dut_grants.size() > 1) ? dut_grants[1] : 32'hx, 32'h0000_0400);

      // Starvation release: data held continuously with fetch pending
      next_lat = 1;
      dut_grants.delete();
      i_req = 1'b1;
      i_addr = 32'h1111_0000;
      d_req = 1'b1;
      d_we = 1'b0;
      d_addr = 32'h2222_0000;
      for (int n = 0; n < 80 && dut_grants.size() < 5; n++) cycle();
      for (int k = 0; k < 5; k++)
         chk32($sformatf("starve_grant%0d", k), (k < dut_grants.size()) ? dut_grants[k] : 32'hx, exp033[k]);
      drain(60);
      idle(2);

      // Timeout on a data read: no mem_ack at all
      next_lat = 99;
      mreq_hi = 0;
      d_req = 1'b1;
      d_we = 1'b0;
      d_addr = 32'h0000_3000;
      run_until_ack(0, 40, "d_ack_timeout");
      chk1("bus_err_with_ack", obs_berr, 1'b1);
      chk32("mem_req_cycles", 32'(mreq_hi), 32'(TO));
      d_req = 1'b0;
      idle(2);

      // Flush before grant blocks the access; flush during DBUSY does not
      mreq_hi = 0;
      d_req = 1'b1;
      d_flush = 1'b1;
      d_addr = 32'h0000_5000;
      cycle();
      d_req = 1'b0;
      d_flush = 1'b0;
      idle(3);
      chk32("flush_no_grant", 32'(mreq_hi), 32'd0);
      next_lat = 4;
      n_dack = 0;
      d_req = 1'b1;
      d_we = 1'b1;
      d_wdata = 32'h5A5A_A5A5;
      cycle();
      d_flush = 1'b1;
      run_until_ack(0, 20, "d_ack_flush_busy");
      d_flush = 1'b0;
      d_req = 1'b0;
      idle(2);
      chk32("d_ack_flush_pulses", 32'(n_dack), 32'd1);

      // Asynchronous reset during IBUSY
      next_lat = 10;
      n_iack = 0;
      i_req = 1'b1;
      i_addr = 32'h0000_6000;
      repeat (3) cycle();
      #2;
      rst_n = 1'b0;
      #1;
      chk1("arst_mem_req", mem_req, 1'b0);
      chk1("arst_i_ack", i_ack, 1'b0);
      chk32("arst_mem_addr", mem_addr, 32'h0);
      chk32("arst_i_rdata", i_rdata, 32'h0);
      i_req = 1'b0;
      mem_ack = 1'b0;
      @(negedge clk);
      chk1("arst_hold_mem_req", mem_req, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      act = 0;
      idle_from = t;
      starve = 0;
      i_rdata_m = '0;
      d_rdata_m = '0;
      prev_mreq = 0;
      idle(4);
      chk32("arst_no_i_ack", 32'(n_iack), 32'd0);

      // Randomized traffic with flushes, writes, spurious acks and timeouts
      next_lat = 0;
      for (int n = 0; n < 2500; n++) begin
         if (i_acked) i_req = 1'b0;
         if (d_acked || d_cancel) d_req = 1'b0;
         d_cancel = 0;
         d_flush = 1'b0;
         if (!i_req && $urandom_range(0, 2) == 0) begin
            i_req = 1'b1;
            i_addr = $urandom;
         end
         if (!d_req && $urandom_range(0, 2) == 0) begin
            d_req = 1'b1;
            d_we = 1'($urandom_range(0, 1));
            d_addr = $urandom;
            d_wdata = $urandom;
         end else if (d_req && $urandom_range(0, 9) == 0) begin
            d_flush = 1'b1;
            d_cancel = !(act && a_who == 2 && t > a_g && t <= a_ack);
         end
         cycle();
      end
      d_flush = 1'b0;
      if (d_cancel) d_req = 1'b0;
      drain(100);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
